latency_aware_write_master: RTL and testbench
=============================================

// Module: latency_aware_write_master
// PURPOSE
//  Avalon-MM write master with a CSR slave; the write-direction counterpart of the NIOS read master.
//  Software pushes words into an internal FIFO through the CSR and programs base and length, then pulses go.
//  The master drains the FIFO onto the bus, one word per accepted transfer, until length reaches zero.
//  Sits between the NIOS data bus (CSR slave) and a memory/peripheral slave (master port).
// PARAMETERS
//  DATAWIDTH        32  master data width; must equal 32 (words arrive through the 32-bit CSR)
//  BYTEENABLEWIDTH  4   bytes per word; address/length step
//  ADDRESSWIDTH     32  master address width
//  FIFODEPTH        32  user-to-master FIFO depth in words
//  FIFODEPTH_LOG2   5   log2(FIFODEPTH)
// PORTS
//  clk                  in   1             single clock
//  reset                in   1             synchronous, active-high
//  avs_csr_address      in   4             CSR word address
//  avs_csr_write        in   1             CSR write strobe
//  avs_csr_read         in   1             CSR read strobe
//  avs_csr_writedata    in   32            CSR write data
//  avs_csr_readdata     out  32            CSR read data, registered
//  master_address       out  ADDRESSWIDTH  byte address, word aligned
//  master_write         out  1             write request
//  master_byteenable    out  BYTEENABLEWIDTH  constant all ones
//  master_writedata     out  DATAWIDTH     FIFO head word
//  master_waitrequest   in   1             slave stall
// BEHAVIOUR
//  - Reset: one clk edge with reset=1 clears all state.
//    address=0, length=0, fixed=0, overflow=0, FIFO flushed, avs_csr_readdata=0, master_write=0.
//  - Reset mid-transfer aborts the transfer; the in-flight word is lost; no further writes are issued.
//  - CSR map; write effects take place on the same clk edge as the strobe:
//    0 CONTROL  W: bit0 go, a single-cycle pulse; bit1 fixed_location, latched only on go.
//    1 STATUS   R: bit0 done=(length==0); bit1 fifo_full; bit2 fifo_empty; bit3 overflow (sticky).
//    2 ADDR     R/W: base address; bits[1:0] forced to 0.
//    3 LENGTH   R/W: byte count; bits[1:0] forced to 0.
//    4 DATA     W: pushes writedata into the FIFO.
//  - Unmapped CSR addresses: writes ignored; reads return 0.
//  - CSR read: avs_csr_readdata is valid on the cycle after avs_csr_read (1-cycle latency).
//  - Push to a full FIFO: the word is dropped and overflow is set. overflow clears on go.
//  - go while length!=0 (busy): ignored entirely.
//  - go with length register 0: done stays 1; no bus activity.
//  - On accepted go, the next edge loads address<=ADDR, length<=LENGTH, fixed<=bit1.
//  - master_write = (length!=0) & !fifo_empty. Combinational from registers; no waitrequest dependency.
//  - master_writedata = FIFO head (show-ahead).
//  - Transfer accepted when master_write & !master_waitrequest. On acceptance:
//    pop FIFO; length -= BYTEENABLEWIDTH; address += BYTEENABLEWIDTH unless fixed.
//  - While master_write=1 and waitrequest=1: address, writedata and write are held stable.
//  - FIFO empty while busy: master_write drops; resumes when data arrives. No timeout.
//  - Simultaneous CSR push and bus pop: FIFO used count unchanged; legal when full or empty.
//  - Address wraps modulo 2^ADDRESSWIDTH; no error.
//  - length never underflows: it is a multiple of BYTEENABLEWIDTH and decrements only while nonzero.
// STRUCTURE
//  - Shared package/include: CSR address constants.
//    CSR_CONTROL=0, CSR_STATUS=1, CSR_ADDR=2, CSR_LENGTH=3, CSR_DATA=4.
//  - Also in the package: STATUS bit positions.
//  - Sub-module sync_fifo: single-clock show-ahead FIFO; sync reset; full/empty/usedw outputs.
//    Instantiated once; no vendor megafunction.
//  - Top level holds the CSR decode, go/busy logic, address/length counters and master outputs.
// TESTING
//  1 ADDR=0x1000, LENGTH=16, push 4 words A..D, go, waitrequest=0.
//    -> 4 writes at 0x1000/4/8/C with A..D, one per cycle; then done=1, fifo_empty=1.
//  2 As 1 but go with CONTROL=0x3 (fixed).
//    -> all 4 writes to 0x1000; address unchanged at end.
//  3 As 1 with waitrequest high for 3 cycles on word 2.
//    -> address/writedata held stable during the stall; 4 writes total; final address 0x1010.
//  4 LENGTH=8, go before any push; push 2 words 5 cycles later.
//    -> master_write=0 until the first push, then 2 writes; done=1.
//  5 Push 33 words with no go.
//    -> fifo_full=1 after 32 pushes; overflow=1; next go clears overflow; 32 words drained when LENGTH=128.
//  6 Assert reset after 2 of 4 writes.
//    -> master_write=0, done=1, fifo_empty=1, readdata=0; a second go while busy in a fresh run is ignored.

Source files
------------

// File: rtl/latency_aware_write_master_pkg.sv
// CSR map, STATUS/CONTROL bit positions and helpers
// shared by the write master and its bench.
package latency_aware_write_master_pkg;

  localparam logic [3:0] CSR_CONTROL = 4'd0;
  localparam logic [3:0] CSR_STATUS  = 4'd1;
  localparam logic [3:0] CSR_ADDR    = 4'd2;
  localparam logic [3:0] CSR_LENGTH  = 4'd3;
  localparam logic [3:0] CSR_DATA    = 4'd4;

  localparam int CTRL_GO    = 0;
  localparam int CTRL_FIXED = 1;

  localparam int ST_DONE  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  function automatic logic [31:0] word_align(
    input logic [31:0] v
  );
    return v & ~32'h3;
  endfunction

endpackage

// File: rtl/latency_aware_write_master_if.sv
// Avalon-MM write-only master bus.
// master: address/write/byteenable/writedata out, waitrequest in.
interface latency_aware_write_master_if #(
  parameter int DATAWIDTH       = 32,
  parameter int BYTEENABLEWIDTH = 4,
  parameter int ADDRESSWIDTH    = 32
);
  logic [ADDRESSWIDTH-1:0]    master_address;
  logic                       master_write;
  logic [BYTEENABLEWIDTH-1:0] master_byteenable;
  logic [DATAWIDTH-1:0]       master_writedata;
  logic                       master_waitrequest;

  modport master (
    output master_address,
    output master_write,
    output master_byteenable,
    output master_writedata,
    input  master_waitrequest
  );

  modport slave (
    input  master_address,
    input  master_write,
    input  master_byteenable,
    input  master_writedata,
    output master_waitrequest
  );
endinterface

// File: rtl/latency_aware_write_master_sync_fifo.sv
// Single-clock show-ahead FIFO, sync active-high reset.
// Ports: push/din, pop/dout (head), full, empty, usedw.
module latency_aware_write_master_sync_fifo #(
  parameter int W          = 32,
  parameter int DEPTH      = 32,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [W-1:0]        din,
  input  logic                pop,
  output logic [W-1:0]        dout,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] usedw
);
  localparam logic [DEPTH_LOG2:0] FULL_CNT =
    (DEPTH_LOG2+1)'(DEPTH);

  logic [W-1:0]          mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  wr_en;
  logic                  rd_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign usedw = count;
  assign dout  = mem[rd_ptr];

  // A push into a full FIFO is accepted only when
  // the head leaves on the same edge.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/latency_aware_write_master.sv
// Avalon-MM write master draining a CSR-filled FIFO.
// Ports: clk, reset, avs_csr_* slave, m (master bus).
module latency_aware_write_master
  import latency_aware_write_master_pkg::*;
#(
  parameter int DATAWIDTH       = 32,
  parameter int BYTEENABLEWIDTH = 4,
  parameter int ADDRESSWIDTH    = 32,
  parameter int FIFODEPTH       = 32,
  parameter int FIFODEPTH_LOG2  = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  avs_csr_address,
  input  logic        avs_csr_write,
  input  logic        avs_csr_read,
  input  logic [31:0] avs_csr_writedata,
  output logic [31:0] avs_csr_readdata,
  latency_aware_write_master_if.master m
);
  localparam logic [31:0] LEN_STEP =
    32'(BYTEENABLEWIDTH);
  localparam logic [ADDRESSWIDTH-1:0] ADDR_STEP =
    ADDRESSWIDTH'(BYTEENABLEWIDTH);

  logic [ADDRESSWIDTH-1:0] base_q;
  logic [ADDRESSWIDTH-1:0] addr_q;
  logic [31:0]             len_reg_q;
  logic [31:0]             len_q;
  logic                    fixed_q;
  logic                    ovf_q;

  logic                    busy;
  logic                    go;
  logic                    push;
  logic                    accept;
  logic [31:0]             status;
  logic [31:0]             rd_mux;

  logic [DATAWIDTH-1:0]    fifo_dout;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [FIFODEPTH_LOG2:0] fifo_usedw;

  assign busy = (len_q != '0);

  // go while busy is dropped entirely, so fixed and
  // overflow are untouched by it too.
  assign go = avs_csr_write
            & (avs_csr_address == CSR_CONTROL)
            & avs_csr_writedata[CTRL_GO]
            & ~busy;

  assign push = avs_csr_write
              & (avs_csr_address == CSR_DATA);

  assign accept = m.master_write
                & ~m.master_waitrequest;

  latency_aware_write_master_sync_fifo #(
    .W          (DATAWIDTH),
    .DEPTH      (FIFODEPTH),
    .DEPTH_LOG2 (FIFODEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (avs_csr_writedata[DATAWIDTH-1:0]),
    .pop   (accept),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .usedw (fifo_usedw)
  );

  assign m.master_address    = addr_q;
  assign m.master_write      = busy & (fifo_usedw != '0);
  assign m.master_byteenable = '1;
  assign m.master_writedata  = fifo_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q    <= '0;
      addr_q    <= '0;
      len_reg_q <= '0;
      len_q     <= '0;
      fixed_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      if (avs_csr_write
          && avs_csr_address == CSR_ADDR)
        base_q <= ADDRESSWIDTH'(
          word_align(avs_csr_writedata));
      if (avs_csr_write
          && avs_csr_address == CSR_LENGTH)
        len_reg_q <= word_align(avs_csr_writedata);
      if (go) begin
        addr_q  <= base_q;
        len_q   <= len_reg_q;
        fixed_q <= avs_csr_writedata[CTRL_FIXED];
        ovf_q   <= 1'b0;
      end else if (accept) begin
        len_q <= len_q - LEN_STEP;
        if (!fixed_q) addr_q <= addr_q + ADDR_STEP;
      end
      if (push && fifo_full && !accept)
        ovf_q <= 1'b1;
    end
  end

  always_comb begin
    status           = '0;
    status[ST_DONE]  = ~busy;
    status[ST_FULL]  = fifo_full;
    status[ST_EMPTY] = fifo_empty;
    status[ST_OVF]   = ovf_q;
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (avs_csr_address == CSR_STATUS): rd_mux = status;
      (avs_csr_address == CSR_ADDR):   rd_mux = 32'(base_q);
      (avs_csr_address == CSR_LENGTH): rd_mux = len_reg_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)             avs_csr_readdata <= '0;
    else if (avs_csr_read) avs_csr_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_latency_aware_write_master.sv
// Scoreboard bench for latency_aware_write_master:
// directed CSR programs, bus writes checked by a monitor.
module tb_latency_aware_write_master;
  import latency_aware_write_master_pkg::*;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } xfer_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  avs_csr_address;
  logic        avs_csr_write;
  logic        avs_csr_read;
  logic [31:0] avs_csr_writedata;
  logic [31:0] avs_csr_readdata;

  int checks = 0;
  int errors = 0;

  xfer_t       exp_q[$];
  logic [31:0] rd_q[$];

  latency_aware_write_master_if bus ();

  latency_aware_write_master dut (
    .clk               (clk),
    .reset             (reset),
    .avs_csr_address   (avs_csr_address),
    .avs_csr_write     (avs_csr_write),
    .avs_csr_read      (avs_csr_read),
    .avs_csr_writedata (avs_csr_writedata),
    .avs_csr_readdata  (avs_csr_readdata),
    .m                 (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Monitor: CSR read data one cycle after the strobe,
  // bus transfers on acceptance, stability while stalled.
  logic        rd_pend = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] held_a;
  logic [31:0] held_d;

  always @(negedge clk) begin
    if (reset) begin
      rd_pend    = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (rd_pend) begin
        logic [31:0] e;
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL csr_read: got %h, none expected",
                   avs_csr_readdata);
        end else begin
          e = rd_q.pop_front();
          if (avs_csr_readdata !== e) begin
            errors++;
            $display("FAIL csr_read: got %h expected %h",
                     avs_csr_readdata, e);
          end
        end
      end
      rd_pend = avs_csr_read;

      if (stall_prev) begin
        checks++;
        if (bus.master_write !== 1'b1
            || bus.master_address !== held_a
            || bus.master_writedata !== held_d) begin
          errors++;
          $display("FAIL stall_hold: got w=%b a=%h d=%h expected w=1 a=%h d=%h",
                   bus.master_write, bus.master_address,
                   bus.master_writedata, held_a, held_d);
        end
      end

      stall_prev = 1'b0;
      if (bus.master_write === 1'b1) begin
        if (bus.master_waitrequest) begin
          stall_prev = 1'b1;
          held_a     = bus.master_address;
          held_d     = bus.master_writedata;
        end else begin
          xfer_t x;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL bus_write: got a=%h d=%h, none expected",
                     bus.master_address, bus.master_writedata);
          end else begin
            x = exp_q.pop_front();
            if (bus.master_address !== x.a
                || bus.master_writedata !== x.d
                || bus.master_byteenable !== 4'hF) begin
              errors++;
              $display("FAIL bus_write: got a=%h d=%h be=%h expected a=%h d=%h be=f",
                       bus.master_address, bus.master_writedata,
                       bus.master_byteenable, x.a, x.d);
            end
          end
        end
      end
    end
  end

  task automatic csr_wr(input logic [3:0] a,
                        input logic [31:0] d);
    avs_csr_address   = a;
    avs_csr_writedata = d;
    avs_csr_write     = 1'b1;
    @(posedge clk);
    #1;
    avs_csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [3:0] a,
                        input logic [31:0] e);
    rd_q.push_back(e);
    avs_csr_address = a;
    avs_csr_read    = 1'b1;
    @(posedge clk);
    #1;
    avs_csr_read = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] d,
                          input logic [31:0] a);
    xfer_t x;
    x.a = a;
    x.d = d;
    exp_q.push_back(x);
    csr_wr(CSR_DATA, d);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.master_write)
           && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL %s: drain timeout, %0d writes missing, expected 0",
               name, exp_q.size());
    end
  endtask

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, got, exp);
    end
  endtask

  initial begin
    logic [31:0] w [4];
    int n;
    w[0] = 32'hAAAA_0001;
    w[1] = 32'hBBBB_0002;
    w[2] = 32'hCCCC_0003;
    w[3] = 32'hDDDD_0004;

    reset                   = 1'b1;
    avs_csr_address         = '0;
    avs_csr_write           = 1'b0;
    avs_csr_read            = 1'b0;
    avs_csr_writedata       = '0;
    bus.master_waitrequest  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("reset_readdata", avs_csr_readdata, 32'h0);
    chk("reset_write", 32'(bus.master_write), 32'h0);
    chk("reset_addr", bus.master_address, 32'h0);
    csr_rd(CSR_STATUS, 32'h5);

    // 1: incrementing burst
    csr_wr(CSR_ADDR, 32'h1000);
    csr_wr(CSR_LENGTH, 32'd16);
    for (int i = 0; i < 4; i++)
      push_exp(w[i], 32'h1000 + 32'(4*i));
    csr_wr(CSR_CONTROL, 32'h1);
    wait_idle("t1_drain");
    csr_rd(CSR_STATUS, 32'h5);
    chk("t1_final_addr", bus.master_address, 32'h1010);

    // 2: fixed location
    for (int i = 0; i < 4; i++)
      push_exp(w[i], 32'h1000);
    csr_wr(CSR_CONTROL, 32'h3);
    wait_idle("t2_drain");
    chk("t2_final_addr", bus.master_address, 32'h1000);
    csr_rd(CSR_STATUS, 32'h5);

    // 3: three-cycle stall on the second word
    for (int i = 0; i < 4; i++)
      push_exp(w[i], 32'h1000 + 32'(4*i));
    csr_wr(CSR_CONTROL, 32'h1);
    @(posedge clk);
    #1;
    bus.master_waitrequest = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.master_waitrequest = 1'b0;
    wait_idle("t3_drain");
    chk("t3_final_addr", bus.master_address, 32'h1010);

    // 4: go before data
    csr_wr(CSR_LENGTH, 32'd8);
    csr_wr(CSR_CONTROL, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("t4_no_write", 32'(bus.master_write), 32'h0);
    end
    push_exp(32'h4444_0000, 32'h1000);
    push_exp(32'h4444_0001, 32'h1004);
    wait_idle("t4_drain");
    csr_rd(CSR_STATUS, 32'h5);

    // 5: fill, overflow, drain 32
    for (int i = 0; i < 32; i++)
      push_exp(32'h5000_0000 + 32'(i),
               32'h1000 + 32'(4*i));
    csr_rd(CSR_STATUS, 32'h3);
    csr_wr(CSR_DATA, 32'hDEAD_BEEF);
    csr_rd(CSR_STATUS, 32'hB);
    csr_wr(CSR_LENGTH, 32'd128);
    csr_rd(CSR_LENGTH, 32'd128);
    csr_wr(CSR_CONTROL, 32'h1);
    wait_idle("t5_drain");
    csr_rd(CSR_STATUS, 32'h5);

    // 6: reset mid-transfer
    csr_wr(CSR_LENGTH, 32'd16);
    for (int i = 0; i < 4; i++)
      push_exp(w[i], 32'h1000 + 32'(4*i));
    csr_wr(CSR_CONTROL, 32'h1);
    n = 0;
    while (exp_q.size() != 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t6_two_written", 32'(exp_q.size()), 32'd2);
    reset                  = 1'b1;
    bus.master_waitrequest = 1'b1;
    @(posedge clk);
    #1;
    reset                  = 1'b0;
    bus.master_waitrequest = 1'b0;
    exp_q.delete();
    chk("t6_write", 32'(bus.master_write), 32'h0);
    chk("t6_readdata", avs_csr_readdata, 32'h0);
    csr_rd(CSR_STATUS, 32'h5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("t6_idle", 32'(bus.master_write), 32'h0);
    end

    // fresh run: alignment, busy go ignored, unmapped
    csr_wr(CSR_ADDR, 32'h2003);
    csr_rd(CSR_ADDR, 32'h2000);
    csr_wr(CSR_LENGTH, 32'h0000_000B);
    csr_rd(CSR_LENGTH, 32'd8);
    csr_wr(CSR_CONTROL, 32'h1);
    csr_wr(CSR_ADDR, 32'h3000);
    csr_wr(CSR_LENGTH, 32'd16);
    csr_wr(CSR_CONTROL, 32'h3);
    push_exp(32'h6666_0000, 32'h2000);
    push_exp(32'h6666_0001, 32'h2004);
    wait_idle("t6_fresh_drain");
    csr_rd(CSR_STATUS, 32'h5);
    csr_rd(4'd7, 32'h0);
    csr_rd(CSR_DATA, 32'h0);

    // go with length 0: no bus activity
    csr_wr(CSR_LENGTH, 32'd0);
    csr_wr(CSR_DATA, 32'h7777_0000);
    csr_wr(CSR_CONTROL, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("zero_len_idle", 32'(bus.master_write), 32'h0);
    end
    csr_rd(CSR_STATUS, 32'h1);

    repeat (3) @(posedge clk);
    #1;
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
